// File: rtl/fht_adc_loader.sv
// ---------------------------------------------------------------------------
// fht_adc_loader
//
// Feeds one frame of 4*BANK_SIZE raw ADC samples into the four FHT RAM banks.
// Sample n is written to bank n mod 4 at address n div 4. Each sample is
// left-aligned into the D_BIT fixed-point word. When the frame is complete,
// the loader pulses oSTART. It then refuses samples until the transform
// signals completion by dropping iRDY and raising it again.
//
// Ports
//   iCLK        clock
//   iRESET      asynchronous active-low reset
//   iADC_DATA   signed ADC sample
//   iADC_VALID  sample present this cycle (the source cannot stall)
//   oADC_READY  loader accepts a sample this cycle (registered)
//   iRDY        fht_top oRDY
//   oSTART      one-cycle start pulse to fht_top
//   oWE         one-hot bank write enable
//   oADDR_WR    write address, shared by all banks
//   oDATA       write data, shared by all banks
//   oOVF        sticky flag: a sample arrived while not ready and was dropped
//   iOVF_CLR    clears oOVF (a same-cycle set takes priority)
//   oFRAME_CNT  frames handed to the FHT, wraps modulo 2**16
// ---------------------------------------------------------------------------
module fht_adc_loader #(
  parameter int ADC_WIDTH = 12,
  parameter int D_BIT     = 22,
  parameter int A_BIT     = 8
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic [ADC_WIDTH-1:0] iADC_DATA,
  input  logic                 iADC_VALID,
  output logic                 oADC_READY,
  input  logic                 iRDY,
  output logic                 oSTART,
  output logic [3:0]           oWE,
  output logic [A_BIT-1:0]     oADDR_WR,
  output logic [D_BIT-1:0]     oDATA,
  output logic                 oOVF,
  input  logic                 iOVF_CLR,
  output logic [15:0]          oFRAME_CNT
);

  localparam int N_BIT = A_BIT + 2;
  localparam logic [N_BIT-1:0] N_LAST = '1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT_LO,
    ST_WAIT_HI
  } state_e;

  state_e           state_q, state_d;
  logic [N_BIT-1:0] n_q;
  logic             accept;

  // Only oADC_READY gates acceptance, so the write path and the FSM always
  // agree on which samples were taken.
  assign accept = iADC_VALID & oADC_READY;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD:    if (accept && (n_q == N_LAST)) state_d = ST_START;
      ST_START:   state_d = ST_WAIT_LO;
      ST_WAIT_LO: if (!iRDY) state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (iRDY) state_d = ST_LOAD;
      default:    state_d = ST_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q    <= ST_LOAD;
      n_q        <= '0;
      oADC_READY <= 1'b0;
      oSTART     <= 1'b0;
      oWE        <= '0;
      oADDR_WR   <= '0;
      oDATA      <= '0;
      oOVF       <= 1'b0;
      oFRAME_CNT <= '0;
    end else begin
      state_q <= state_d;

      // Ready is a registered look-ahead: it is high in the cycles in which
      // the FSM sits in LOAD.
      oADC_READY <= (state_d == ST_LOAD);

      // The write strobe and its address/data are single-cycle and return to
      // zero unless a sample was accepted at this edge.
      oWE      <= '0;
      oADDR_WR <= '0;
      oDATA    <= '0;
      if (accept) begin
        oWE      <= 4'b0001 << n_q[1:0];
        oADDR_WR <= n_q[N_BIT-1:2];
        oDATA    <= {iADC_DATA, {(D_BIT-ADC_WIDTH){1'b0}}};
        n_q      <= n_q + 1'b1;  // wraps to 0 after the last sample of a frame
      end

      // The START state lasts one cycle, so this pulse lands one cycle after
      // the write of the final sample and never overlaps a write.
      oSTART <= (state_q == ST_START);

      if ((state_q == ST_WAIT_HI) && iRDY) oFRAME_CNT <= oFRAME_CNT + 16'd1;

      // Set has priority over clear so that a drop is never lost.
      if (iADC_VALID && !oADC_READY) oOVF <= 1'b1;
      else if (iOVF_CLR)             oOVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fht_adc_loader.sv
`timescale 1ns/1ps
// Testbench for fht_adc_loader: directed stimulus, a scoreboard queue of
// expected bank writes, and a monitor that pops one entry per observed write.
module tb_fht_adc_loader;

  logic        clk;
  logic        rst_n;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic        adc_ready;
  logic        rdy;
  logic        start;
  logic [3:0]  we;
  logic [7:0]  addr_wr;
  logic [21:0] data;
  logic        ovf;
  logic        ovf_clr;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;

  logic [33:0] sb[$];   // {we, addr, data}
  logic [9:0]  n_m;     // bench model of the sample counter

  fht_adc_loader #(.ADC_WIDTH(12), .D_BIT(22), .A_BIT(8)) dut (
    .iCLK       (clk),
    .iRESET     (rst_n),
    .iADC_DATA  (adc_data),
    .iADC_VALID (adc_valid),
    .oADC_READY (adc_ready),
    .iRDY       (rdy),
    .oSTART     (start),
    .oWE        (we),
    .oADDR_WR   (addr_wr),
    .oDATA      (data),
    .oOVF       (ovf),
    .iOVF_CLR   (ovf_clr),
    .oFRAME_CNT (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one valid sample for one cycle and queue the write it must cause.
  task automatic put(input logic [11:0] v);
    logic [3:0] we_e;
    we_e = 4'b0001 << n_m[1:0];
    adc_valid = 1'b1;
    adc_data  = v;
    sb.push_back({we_e, n_m[9:2], v, 10'b0});
    n_m = n_m + 10'd1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    adc_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, adc_ready, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_we"}, we, 0);
    check({tag, "_addr"}, addr_wr, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_frame"}, frame_cnt, 0);
  endtask

  // Monitor: every observed write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start) start_cnt++;
      if (start && we != 4'b0000) check("write_with_start", {60'd0, we}, 64'd0);
      if (we != 4'b0000) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {30'd0, we, addr_wr, data}, 64'd0);
        end else begin
          logic [33:0] exp;
          exp = sb.pop_front();
          check("sb_write", {30'd0, we, addr_wr, data}, {30'd0, exp});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; adc_valid = 1'b0; adc_data = '0; rdy = 1'b1; ovf_clr = 1'b0;
    n_m = '0;

    repeat (2) @(posedge clk); #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", adc_ready, 1);

    // Frame 1: sample 0 is -1, then 1..1023 back to back.
    put(12'hFFF);
    check("neg_we", we, 4'b0001);
    check("neg_addr", addr_wr, 0);
    check("neg_data", data, 22'h3FFC00);
    for (int i = 1; i < 1024; i++) begin
      put(i[11:0]);
      if (i == 5) begin
        check("s5_we", we, 4'b0010);
        check("s5_addr", addr_wr, 1);
        check("s5_data", data, 22'h001400);
      end
    end
    adc_valid = 1'b0;
    check("ready_low_after_last", adc_ready, 0);
    check("no_start_with_last_write", start, 0);
    @(posedge clk); #1;
    check("start_pulse", start, 1);
    @(posedge clk); #1;
    check("start_one_cycle", start, 0);
    check("start_count_f1", start_cnt, 1);

    // Overflow while waiting for the transform (iRDY still 1).
    adc_valid = 1'b1; adc_data = 12'h123;
    repeat (3) begin @(posedge clk); #1; end
    check("ovf_set", ovf, 1);
    check("ready_while_wait", adc_ready, 0);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    check("ovf_set_wins", ovf, 1);
    adc_valid = 1'b0;
    @(posedge clk); #1;
    check("ovf_cleared", ovf, 0);
    ovf_clr = 1'b0;

    rdy = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("ready_low_rdy0", adc_ready, 0);
    check("frame_cnt_before", frame_cnt, 0);
    rdy = 1'b1;
    @(posedge clk); #1;
    check("ready_back", adc_ready, 1);
    check("frame_cnt_after", frame_cnt, 1);

    // Frame 2: valid toggling, then back to back up to 300 samples.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        put(12'(100 + i));
        if (i == 0) begin
          check("f2_first_we", we, 4'b0001);
          check("f2_first_addr", addr_wr, 0);
        end
      end else begin
        idle();
        check("gap_no_write", we, 0);
      end
    end
    for (int i = 4; i < 300; i++) put(i[11:0]);
    adc_valid = 1'b0;

    // Asynchronous reset mid-frame.
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    check("sb_empty_at_reset", sb.size(), 0);
    n_m = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_midreset", adc_ready, 1);

    // Frame 3: must restart at bank 0 / address 0 and need all 1024 samples.
    put(12'h7FF);
    check("f3_first_we", we, 4'b0001);
    check("f3_first_addr", addr_wr, 0);
    check("f3_first_data", data, 22'h1FFC00);
    for (int i = 1; i < 1023; i++) put(i[11:0]);
    adc_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("no_start_partial", start_cnt, 1);
    check("ready_before_last", adc_ready, 1);
    put(12'h800);
    adc_valid = 1'b0;
    check("f3_last_data", data, 22'h200000);
    check("f3_ready_low", adc_ready, 0);
    @(posedge clk); #1;
    check("f3_start_pulse", start, 1);
    @(posedge clk); #1;
    check("start_count_f3", start_cnt, 2);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
